// File: rtl/fc_layer_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fc_layer_ctrl_pkg
// Brief  : State encodings and size helpers shared by the FC layer sequencer.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package fc_layer_ctrl_pkg;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_feed  = 3'd1;
  localparam logic [2:0] c_st_drain = 3'd2;
  localparam logic [2:0] c_st_wait  = 3'd3;
  localparam logic [2:0] c_st_hold  = 3'd4;
  localparam logic [2:0] c_st_clear = 3'd5;

  function automatic int f_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int f_num_words(input int side, input int ch);
    return side * side * ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_feed_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fc_feed_addr_gen
// Brief  : Read counter, buffer address generation and 2-stage ce/data pipe.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module fc_feed_addr_gen
  import fc_layer_ctrl_pkg::*;
#(
  parameter int I_BW      = 16,
  parameter int ADDR_BW   = 8,
  parameter int BASE_ADDR = 0,
  parameter int N         = 192
) (
  input  logic               clk,
  input  logic               global_rst,
  input  logic               i_clr,
  input  logic               i_feed,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [I_BW-1:0]    i_rd_data,
  output logic               o_rd_en,
  output logic [ADDR_BW-1:0] o_rd_addr,
  output logic               o_last_rd,
  output logic               o_fc_ce,
  output logic [I_BW-1:0]    o_fc_data,
  output logic               o_empty
);

  localparam int c_cnt_w = f_clog2(N) + 1;

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_v1;
  logic               r_fc_ce;
  logic [I_BW-1:0]    r_fc_data;
  logic               w_rd_en;

  assign w_rd_en   = i_feed & ~i_stall & ~i_flush;
  assign o_rd_en   = w_rd_en;
  assign o_rd_addr = i_feed ? (ADDR_BW'(BASE_ADDR) + ADDR_BW'(r_cnt)) : '0;
  assign o_last_rd = w_rd_en & (r_cnt == c_cnt_w'(N - 1));
  assign o_empty   = ~r_v1 & ~w_rd_en;
  assign o_fc_ce   = r_fc_ce;
  assign o_fc_data = r_fc_data;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      r_cnt     <= '0;
      r_v1      <= 1'b0;
      r_fc_ce   <= 1'b0;
      r_fc_data <= '0;
    end else begin
      if (i_clr)
        r_cnt <= '0;
      else if (w_rd_en)
        r_cnt <= r_cnt + c_cnt_w'(1);
      // A flush kills words still in flight so nothing leaks past an abort.
      if (i_flush) begin
        r_v1    <= 1'b0;
        r_fc_ce <= 1'b0;
      end else begin
        r_v1    <= w_rd_en;
        r_fc_ce <= r_v1;
      end
      r_fc_data <= i_rd_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fc_layer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fc_layer_ctrl
// Brief  : Streams the flattened feature map into the FC datapath, then
//          returns the class on a valid/ready handshake. Optional result
//          watchdog enabled by defining FC_CTRL_WDOG_EN.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module fc_layer_ctrl
  import fc_layer_ctrl_pkg::*;
#(
  parameter int I_BW        = 16,
  parameter int I_SIZE      = 4,
  parameter int CI          = 12,
  parameter int ADDR_BW     = 8,
  parameter int BASE_ADDR   = 0,
  parameter int WDOG_CYCLES = 64
) (
  input  logic               clk,
  input  logic               global_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_stall,
  output logic               o_busy,
  output logic               o_rd_en,
  output logic [ADDR_BW-1:0] o_rd_addr,
  input  logic [I_BW-1:0]    i_rd_data,
  output logic               o_fc_ce,
  output logic [I_BW-1:0]    o_fc_data,
  output logic               o_fc_rst_processEnd,
  input  logic               i_fc_en,
  input  logic [3:0]         i_fc_class,
  output logic [3:0]         o_class,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_err
);

  localparam int c_num_words = f_num_words(I_SIZE, CI);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [3:0] r_class;
  logic       w_abort;
  logic       w_capture;
  logic       w_last_rd;
  logic       w_empty;
  logic       w_wdog_hit;

  assign w_abort = i_abort & (r_state != c_st_idle);

  fc_feed_addr_gen #(
    .I_BW      (I_BW),
    .ADDR_BW   (ADDR_BW),
    .BASE_ADDR (BASE_ADDR),
    .N         (c_num_words)
  ) u_feed (
    .clk        (clk),
    .global_rst (global_rst),
    .i_clr      ((r_state == c_st_idle) & i_start),
    .i_feed     (r_state == c_st_feed),
    .i_stall    (i_stall),
    .i_flush    (w_abort),
    .i_rd_data  (i_rd_data),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .o_last_rd  (w_last_rd),
    .o_fc_ce    (o_fc_ce),
    .o_fc_data  (o_fc_data),
    .o_empty    (w_empty)
  );

`ifdef FC_CTRL_WDOG_EN
  localparam int c_wdog_w = f_clog2(WDOG_CYCLES) + 1;
  logic [c_wdog_w-1:0] r_wdog;

  // Held at zero outside WAIT_RES, so every entry starts a fresh count.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst)
      r_wdog <= '0;
    else if (r_state != c_st_wait)
      r_wdog <= '0;
    else
      r_wdog <= r_wdog + c_wdog_w'(1);
  end

  assign w_wdog_hit = (r_state == c_st_wait) & ~i_fc_en &
                      (r_wdog == c_wdog_w'(WDOG_CYCLES - 1));
`else
  // No watchdog: the comparison is constant false for any legal setting.
  assign w_wdog_hit = (WDOG_CYCLES < 0);
`endif

  assign o_err = w_wdog_hit & ~w_abort;

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      c_st_idle:  if (i_start) w_next = c_st_feed;
      c_st_feed:  if (w_abort) w_next = c_st_clear;
                  else if (w_last_rd) w_next = c_st_drain;
      c_st_drain: if (w_abort) w_next = c_st_clear;
                  else if (w_empty) w_next = c_st_wait;
      c_st_wait: begin
        if (w_abort)
          w_next = c_st_clear;
        else if (i_fc_en) begin
          w_next    = c_st_hold;
          w_capture = 1'b1;
        end else if (w_wdog_hit)
          w_next = c_st_clear;
      end
      c_st_hold:  if (w_abort || i_ready) w_next = c_st_clear;
      c_st_clear: w_next = c_st_idle;
      default:    w_next = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      r_state <= c_st_idle;
      r_class <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_class <= i_fc_class;
    end
  end

  assign o_busy              = (r_state != c_st_idle);
  assign o_valid             = (r_state == c_st_hold);
  assign o_fc_rst_processEnd = (r_state == c_st_clear);
  assign o_class             = r_class;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_fc_layer_ctrl
// Brief  : Directed self-checking bench for fc_layer_ctrl (default build).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_fc_layer_ctrl;

  localparam int I_BW    = 16;
  localparam int ADDR_BW = 8;
  localparam int N       = 192;

  logic               clk = 1'b0;
  logic               global_rst = 1'b1;
  logic               i_start = 1'b0;
  logic               i_abort = 1'b0;
  logic               i_stall = 1'b0;
  logic               o_busy;
  logic               o_rd_en;
  logic [ADDR_BW-1:0] o_rd_addr;
  logic [I_BW-1:0]    i_rd_data = '0;
  logic               o_fc_ce;
  logic [I_BW-1:0]    o_fc_data;
  logic               o_fc_rst_processEnd;
  logic               i_fc_en = 1'b0;
  logic [3:0]         i_fc_class = 4'd0;
  logic [3:0]         o_class;
  logic               o_valid;
  logic               i_ready = 1'b0;
  logic               o_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fc_layer_ctrl #(
    .I_BW (I_BW), .I_SIZE (4), .CI (12), .ADDR_BW (ADDR_BW),
    .BASE_ADDR (0), .WDOG_CYCLES (64)
  ) dut (
    .clk                 (clk),
    .global_rst          (global_rst),
    .i_start             (i_start),
    .i_abort             (i_abort),
    .i_stall             (i_stall),
    .o_busy              (o_busy),
    .o_rd_en             (o_rd_en),
    .o_rd_addr           (o_rd_addr),
    .i_rd_data           (i_rd_data),
    .o_fc_ce             (o_fc_ce),
    .o_fc_data           (o_fc_data),
    .o_fc_rst_processEnd (o_fc_rst_processEnd),
    .i_fc_en             (i_fc_en),
    .i_fc_class          (i_fc_class),
    .o_class             (o_class),
    .o_valid             (o_valid),
    .i_ready             (i_ready),
    .o_err               (o_err)
  );

  // Buffer model: word k holds value k, returned one cycle after the read.
  always @(posedge clk) if (o_rd_en) i_rd_data <= I_BW'(o_rd_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor, sampled on the falling edge.
  logic            mon_clr = 1'b0;
  int              start_mark = 0;
  int              rd_cnt = 0, first_rd = -1, last_rd = -1;
  int              ce_cnt = 0, first_ce = -1, last_ce = -1;
  int              seq_err = 0, pe_cnt = 0, err_cnt = 0;
  logic [I_BW-1:0] exp_word = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      rd_cnt <= 0; first_rd <= -1; last_rd <= -1;
      ce_cnt <= 0; first_ce <= -1; last_ce <= -1;
      seq_err <= 0; pe_cnt <= 0; err_cnt <= 0; exp_word <= '0;
    end else begin
      if (o_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (rd_cnt == 0) first_rd <= cyc - start_mark;
        last_rd <= cyc - start_mark;
      end
      if (o_fc_ce) begin
        ce_cnt <= ce_cnt + 1;
        if (ce_cnt == 0) first_ce <= cyc - start_mark;
        last_ce <= cyc - start_mark;
        if (o_fc_data != exp_word) seq_err <= seq_err + 1;
        exp_word <= exp_word + 1'b1;
      end
      if (o_fc_rst_processEnd) pe_cnt <= pe_cnt + 1;
      if (o_err) err_cnt <= err_cnt + 1;
    end
  end

  task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (start sampled at the end of cycle 0).
  task automatic start_image();
    step();
    mon_clr = 1'b1; i_start = 1'b1; start_mark = cyc;
    step();
    mon_clr = 1'b0; i_start = 1'b0;
  endtask

  task automatic wait_rd_addr(input int addr, input string tag);
    int guard = 0;
    while (!(o_rd_en && o_rd_addr == ADDR_BW'(addr)) && guard < 400) begin
      step();
      guard++;
    end
    t_check(tag, {31'd0, o_rd_en && o_rd_addr == ADDR_BW'(addr)}, 32'd1);
  endtask

  task automatic wait_ce(input int target, input string tag);
    int guard = 0;
    while (ce_cnt != target && guard < 600) begin
      step();
      guard++;
    end
    t_check(tag, ce_cnt, target);
  endtask

  // Entered in the first WAIT_RES cycle.
  task automatic finish_image(input logic [3:0] cls, input int hold_cycles, input string tag);
    int bad = 0;
    @(negedge clk);
    t_check({tag, "_wait"}, {o_busy, o_valid, o_fc_ce, o_fc_rst_processEnd}, 4'b1000);
    step(); i_fc_en = 1'b1; i_fc_class = cls;
    step(); i_fc_en = 1'b0; i_fc_class = 4'd0;
    @(negedge clk);
    t_check({tag, "_valid"}, {o_valid, o_class}, {1'b1, cls});
    repeat (hold_cycles) begin
      step();
      @(negedge clk);
      if (!o_valid || o_class != cls || o_fc_rst_processEnd) bad++;
    end
    t_check({tag, "_hold"}, bad, 0);
    step(); i_ready = 1'b1;
    @(negedge clk);
    t_check({tag, "_no_pe_yet"}, {31'd0, o_fc_rst_processEnd}, 32'd0);
    step(); i_ready = 1'b0;
    @(negedge clk);
    t_check({tag, "_clear"}, {o_fc_rst_processEnd, o_valid, o_busy}, 3'b101);
    step();
    @(negedge clk);
    t_check({tag, "_idle"}, {o_fc_rst_processEnd, o_busy, o_class}, {2'b00, cls});
  endtask

  task automatic check_stream(input int exp_last_rd, input int exp_last_ce, input string tag);
    t_check({tag, "_rd_cnt"}, rd_cnt, N);
    t_check({tag, "_first_rd"}, first_rd, 1);
    t_check({tag, "_last_rd"}, last_rd, exp_last_rd);
    t_check({tag, "_ce_cnt"}, ce_cnt, N);
    t_check({tag, "_first_ce"}, first_ce, 3);
    t_check({tag, "_last_ce"}, last_ce, exp_last_ce);
    t_check({tag, "_seq_err"}, seq_err, 0);
    t_check({tag, "_pe_cnt"}, pe_cnt, 1);
    t_check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state, while held and after release
    repeat (3) step();
    t_check("rst_held_outs", {o_busy, o_rd_en, o_fc_ce, o_fc_rst_processEnd, o_valid, o_err}, 6'd0);
    step(); global_rst = 1'b0;
    @(negedge clk);
    t_check("rst_outs", {o_busy, o_rd_en, o_fc_ce, o_fc_rst_processEnd, o_valid, o_err}, 6'd0);
    t_check("rst_addr_class", {o_rd_addr, o_class}, 12'd0);

    // Nominal image
    start_image();
    wait_ce(N, "nom_ce_done");
    finish_image(4'd7, 0, "nom");
    check_stream(192, 194, "nom");

    // Stall of 5 cycles at cnt=50, fc_en during FEED ignored, backpressure 20
    start_image();
    wait_rd_addr(49, "stall_reach");
    step(); i_stall = 1'b1;
    @(negedge clk);
    t_check("stall_rd", {o_rd_en, o_rd_addr}, {1'b0, 8'd50});
    repeat (5) step();
    i_stall = 1'b0;
    wait_rd_addr(120, "fc_en_reach");
    i_fc_en = 1'b1; i_fc_class = 4'd9;
    step(); i_fc_en = 1'b0; i_fc_class = 4'd0;
    wait_ce(N, "stall_ce_done");
    t_check("fc_en_ignored", o_class, 4'd7);
    finish_image(4'd3, 20, "bp");
    check_stream(197, 199, "stall");

    // Abort in IDLE has no effect
    step(); i_abort = 1'b1;
    @(negedge clk);
    t_check("idle_abort", {o_busy, o_fc_rst_processEnd}, 2'b00);
    step(); i_abort = 1'b0;
    @(negedge clk);
    t_check("idle_abort_after", {o_busy, o_fc_rst_processEnd}, 2'b00);

    // Abort at cnt=100
    start_image();
    wait_rd_addr(99, "abort_reach");
    step(); i_abort = 1'b1;
    @(negedge clk);
    t_check("abort_no_rd", {31'd0, o_rd_en}, 32'd0);
    step(); i_abort = 1'b0;
    @(negedge clk);
    t_check("abort_clear", {o_fc_rst_processEnd, o_busy, o_valid, o_fc_ce}, 4'b1100);
    step();
    @(negedge clk);
    t_check("abort_idle", {o_busy, o_fc_rst_processEnd}, 2'b00);
    repeat (8) step();
    t_check("abort_ce_cnt", ce_cnt, 99);
    t_check("abort_seq_err", seq_err, 0);
    t_check("abort_pe_cnt", pe_cnt, 1);
    t_check("abort_class_held", o_class, 4'd3);

    // Full image after abort; start pulse mid-FEED ignored
    start_image();
    wait_rd_addr(60, "restart_reach");
    i_start = 1'b1;
    step(); i_start = 1'b0;
    wait_ce(N, "rec_ce_done");
    finish_image(4'd5, 0, "rec");
    check_stream(192, 194, "rec");

    // Asynchronous reset mid-FEED
    start_image();
    wait_rd_addr(30, "arst_reach");
    #2 global_rst = 1'b1;
    #1;
    t_check("arst_outs", {o_busy, o_rd_en, o_fc_ce, o_fc_rst_processEnd, o_valid, o_err}, 6'd0);
    t_check("arst_addr_class", {o_rd_addr, o_class}, 12'd0);
    step(); global_rst = 1'b0;
    start_image();
    wait_ce(N, "post_rst_ce_done");
    finish_image(4'd7, 0, "post_rst");
    check_stream(192, 194, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
